// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS 32-bit registers with byte strobes, SLVERR on
// out-of-range indices, one outstanding write and one outstanding read.
module axi4lite_reg_slave #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 6,
    parameter int NUM_REGS     = 4
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [C_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                       S_AXI_AWPROT,
    input  logic                             S_AXI_AWVALID,
    output logic                             S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                             S_AXI_WVALID,
    output logic                             S_AXI_WREADY,
    output logic [1:0]                       S_AXI_BRESP,
    output logic                             S_AXI_BVALID,
    input  logic                             S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                       S_AXI_ARPROT,
    input  logic                             S_AXI_ARVALID,
    output logic                             S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RVALID,
    input  logic                             S_AXI_RREADY,
    output logic [C_DATA_WIDTH*NUM_REGS-1:0] REG_OUT
);
    localparam int IDX_W = C_ADDR_WIDTH - 2;
    localparam int NBYTES = C_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [C_DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                    aw_held;
    logic                    w_held;
    logic [IDX_W-1:0]        aw_idx_q;
    logic [C_DATA_WIDTH-1:0] wdata_q;
    logic [NBYTES-1:0]       wstrb_q;
    logic                    commit;
    logic [IDX_W-1:0]        ar_idx;
    logic [C_DATA_WIDTH-1:0] rd_word;
    logic                    unused_bits;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < (IDX_W + 1)'(NUM_REGS);
    endfunction

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // READY depends only on held state, so no VALID-to-READY combinational path exists
    assign S_AXI_AWREADY = !aw_held && !S_AXI_BVALID && !ARESET;
    assign S_AXI_WREADY  = !w_held && !S_AXI_BVALID && !ARESET;
    assign S_AXI_ARREADY = !S_AXI_RVALID && !ARESET;
    assign commit        = aw_held && w_held;
    assign ar_idx        = S_AXI_ARADDR[C_ADDR_WIDTH-1:2];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_held  <= 1'b1;
                aw_idx_q <= S_AXI_AWADDR[C_ADDR_WIDTH-1:2];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_held  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= in_range(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Out-of-range indices match no k, so a SLVERR commit leaves the bank untouched
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else if (commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (aw_idx_q == IDX_W'(k)) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (wstrb_q[b]) regs[k][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == IDX_W'(k)) rd_word = regs[k];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_word;
            S_AXI_RRESP  <= in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign REG_OUT[C_DATA_WIDTH*k +: C_DATA_WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Randomized scoreboard bench for axi4lite_reg_slave: expected B/R responses are
// queued at issue time from a plain array model and popped by a handshake monitor.
module tb_axi4lite_reg_slave;
    localparam int NR = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [127:0] reg_out;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    logic [31:0] model [NR];
    logic [1:0]  exp_b [$];
    rexp_t       exp_r [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    axi4lite_reg_slave #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(6), .NUM_REGS(NR)) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .REG_OUT(reg_out)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s actual=no handshake required=handshake within budget", name);
    endtask

    function automatic logic [127:0] model_packed();
        logic [127:0] r;
        for (int k = 0; k < NR; k++) r[32*k +: 32] = model[k];
        return r;
    endfunction

    // Monitor: a handshake seen before the edge is consumed on that edge
    always @(negedge clk) begin
        if (!rst && bvalid && bready) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected actual=bvalid required=no response");
            end else begin
                check("bresp", 128'(bresp), 128'(exp_b.pop_front()));
            end
        end
        if (!rst && rvalid && rready) begin
            if (exp_r.size() == 0) begin
                checks++; errors++;
                $display("FAIL r_unexpected actual=rvalid required=no response");
            end else begin
                rexp_t e;
                e = exp_r.pop_front();
                check("rresp", 128'(rresp), 128'(e.resp));
                check("rdata", 128'(rdata), 128'(e.data));
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int bp, input bit chk_order);
        int idx;
        bit ok;
        idx = int'(addr[5:2]);
        exp_b.push_back(idx < NR ? 2'b00 : 2'b10);
        if (idx < NR)
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        bready = (bp == 0);
        fork
            begin
                repeat (aw_dly) @(posedge clk);
                #1 awaddr = addr; awvalid = 1'b1;
                ok = 0;
                for (int i = 0; i < 50 && !ok; i++) begin
                    @(negedge clk);
                    if (awready) ok = 1;
                end
                if (!ok) timeout("aw");
                @(posedge clk); #1 awvalid = 1'b0;
                if (chk_order && ok) begin
                    @(posedge clk); #1;
                    check("commit_latency_bvalid", 128'(bvalid), 128'(1));
                end
            end
            begin
                bit wok;
                repeat (w_dly) @(posedge clk);
                #1 wdata = data; wstrb = strb; wvalid = 1'b1;
                wok = 0;
                for (int i = 0; i < 50 && !wok; i++) begin
                    @(negedge clk);
                    if (chk_order && i == 0) check("w_early_wready", 128'(wready), 128'(1));
                    if (wready) wok = 1;
                end
                if (!wok) timeout("w");
                @(posedge clk); #1 wvalid = 1'b0;
            end
        join
        if (bp > 0) begin
            ok = 0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                if (bvalid) ok = 1;
            end
            if (!ok) timeout("bvalid_bp");
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                check("bp_bvalid", 128'(bvalid), 128'(1));
                check("bp_bresp", 128'(bresp), 128'(exp_b[0]));
                check("bp_awready", 128'(awready), 128'(0));
                check("bp_wready", 128'(wready), 128'(0));
            end
            @(posedge clk); #1 bready = 1'b1;
        end
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bvalid && bready) ok = 1;
        end
        if (!ok) timeout("b");
        @(posedge clk); #1;
        check("reg_out_after_write", reg_out, model_packed());
    endtask

    task automatic do_read(input logic [5:0] addr, input int bp);
        int idx;
        bit ok;
        rexp_t e;
        idx = int'(addr[5:2]);
        e.resp = (idx < NR) ? 2'b00 : 2'b10;
        e.data = (idx < NR) ? model[idx] : 32'h0;
        exp_r.push_back(e);
        rready = (bp == 0);
        araddr = addr; arvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (arready) ok = 1;
        end
        if (!ok) timeout("ar");
        @(posedge clk); #1 arvalid = 1'b0;
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                check("bp_rvalid", 128'(rvalid), 128'(1));
                check("bp_rdata", 128'(rdata), 128'(e.data));
                check("bp_arready", 128'(arready), 128'(0));
            end
            @(posedge clk); #1 rready = 1'b1;
        end
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rvalid && rready) ok = 1;
        end
        if (!ok) timeout("r");
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_val;
        bit ok;
        rexp_t e;
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
        araddr = '0; arprot = '0; arvalid = 0; rready = 1;
        for (int k = 0; k < NR; k++) model[k] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 128'(awready), 128'(0));
        check("rst_wready", 128'(wready), 128'(0));
        check("rst_arready", 128'(arready), 128'(0));
        check("rst_bvalid", 128'(bvalid), 128'(0));
        check("rst_rvalid", 128'(rvalid), 128'(0));
        check("rst_rdata", 128'(rdata), 128'(0));
        check("rst_reg_out", reg_out, 128'(0));
        @(posedge clk); #1 rst = 1'b0;

        for (int k = 0; k < 4; k++) do_write(6'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) do_read(6'(4 * k), 0);
        check("reg_out_seq", reg_out, 128'h00000004_00000003_00000002_00000001);

        do_write(6'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0);
        do_read(6'h04, 0);
        check("strobe_reg1", 128'(reg_out[63:32]), 128'h00BB00DD);

        do_write(6'h08, 32'hCAFE0008, 4'hF, 3, 0, 0, 1);
        do_write(6'h0C, 32'h5A5A5A5A, 4'hF, 0, 0, 5, 0);
        do_read(6'h0C, 5);

        old_val = model[0];
        do_write(6'h10, 32'h12345678, 4'hF, 0, 0, 0, 0);
        do_read(6'h10, 0);
        check("oor_regs_unchanged", 128'(reg_out[31:0]), 128'(old_val));
        do_write(6'h00, 32'hFFFFFFFF, 4'h0, 1, 0, 0, 0);

        // Read sampled on the commit edge must see the pre-write value
        e.resp = 2'b00; e.data = model[2];
        exp_r.push_back(e);
        exp_b.push_back(2'b00);
        model[2] = 32'h13572468;
        awaddr = 6'h08; awvalid = 1; wdata = 32'h13572468; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        check("same_cycle_awready", 128'(awready), 128'(1));
        check("same_cycle_wready", 128'(wready), 128'(1));
        @(posedge clk); #1 awvalid = 0; wvalid = 0; araddr = 6'h08; arvalid = 1;
        @(negedge clk);
        check("commit_edge_arready", 128'(arready), 128'(1));
        @(posedge clk); #1 arvalid = 0;
        repeat (4) @(posedge clk); #1;
        do_read(6'h08, 0);

        for (int t = 0; t < 40; t++) begin
            logic [5:0] a;
            a = 6'($urandom_range(0, 31));
            if ($urandom_range(0, 2) != 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2), 0);
            else
                do_read(a, $urandom_range(0, 2));
        end

        // Reset after AW is held but before W arrives
        awaddr = 6'h04; awvalid = 1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (awready) ok = 1;
        end
        if (!ok) timeout("aw_before_reset");
        @(posedge clk); #1 awvalid = 0;
        #2 rst = 1;
        #1;
        check("midrst_awready", 128'(awready), 128'(0));
        check("midrst_bvalid", 128'(bvalid), 128'(0));
        check("midrst_reg_out", reg_out, 128'(0));
        for (int k = 0; k < NR; k++) model[k] = '0;
        @(posedge clk); @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_bvalid", 128'(bvalid), 128'(0));
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) do_read(6'(4 * k), 0);
        do_write(6'h04, 32'h0BADF00D, 4'hF, 0, 1, 0, 0);
        do_read(6'h04, 0);

        repeat (3) @(posedge clk); #1;
        check("queues_drained", 128'(exp_b.size() + exp_r.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4lite_reg_slave.md
Name: axi4lite_reg_slave

Overview:
- AXI4-Lite responder (slave) that exposes a bank of NUM_REGS 32-bit read/write registers to the AXI VIP master in the block-design test wrapper.
- It is the target the master drives with AXI4LITE_WRITE_BURST and AXI4LITE_READ_BURST.
- It implements independent write-address/write-data capture, byte strobes, B/R response backpressure and SLVERR decoding for out-of-range addresses.
- The register contents are also driven out in parallel for user logic.

Parameters:
- C_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_ADDR_WIDTH, 6, byte-address width.
- NUM_REGS, 4, number of registers, 1..2^(C_ADDR_WIDTH-2).

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1
- S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1
- S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_BVALID  out  1
- S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  C_ADDR_WIDTH
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1
- S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32
- S_AXI_RRESP  out  2
- S_AXI_RVALID  out  1
- S_AXI_RREADY  in  1
- REG_OUT  out  32*NUM_REGS  live register contents; register k occupies bits [32k+31:32k].

Behaviour:
- Reset (ARESET high, asynchronous):
  - All registers, REG_OUT, BVALID, RVALID, RDATA and BRESP/RRESP go to 0.
  - AWREADY, WREADY and ARREADY are forced to 0 while ARESET is high.
  - Holding registers are cleared.
  - Any in-flight transaction is discarded with no response issued.
- Address decode:
  - idx = addr[C_ADDR_WIDTH-1:2]; addr[1:0] is ignored.
  - idx < NUM_REGS is valid; otherwise the access gets SLVERR.
- Write path (single outstanding write):
  - aw_held and w_held flags hold the captured AWADDR and WDATA/WSTRB.
  - AWREADY = !aw_held & !BVALID. WREADY = !w_held & !BVALID.
  - AW and W may arrive in either order or in the same cycle.
  - On the first rising edge where both are held: commit. For each byte b with WSTRB[b]=1 and a valid address, update reg[idx][8b+7:8b]. Then clear both flags, set BVALID=1 and set BRESP (OKAY, or SLVERR with no register change).
  - Minimum latency: AW and W handshakes at edge N, commit and BVALID at edge N+1.
  - BVALID holds with BRESP stable until BVALID&BREADY; it clears on that edge. A new AW/W may be accepted from the following cycle.
  - WSTRB=0 with a valid address: no change, response is OKAY.
- Read path (single outstanding read):
  - ARREADY = !RVALID.
  - On an AR handshake at edge N: register RDATA = reg[idx] (0 if out of range), set RRESP (OKAY/SLVERR) and RVALID=1 at edge N.
  - RDATA and RRESP hold stable until RVALID&RREADY, which clears RVALID.
- Simultaneous events:
  - Read and write paths are fully independent.
  - A read sampled on the same edge as a write commit to the same register returns the pre-write value.
  - A read issued the cycle after the commit returns the new value.
- REG_OUT updates on the commit edge.
- No combinational path exists from any VALID input to any READY output; READY outputs depend only on internal state and ARESET.

Test Plan:
- Sequential write/readback: write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC -> four BRESP=OKAY. Reading back the same addresses -> RDATA 0x1..0x4, RRESP=OKAY. REG_OUT = 0x00000004_00000003_00000002_00000001.
- Byte strobes: write 0xAABBCCDD to 0x4 with WSTRB=4'b0101 over an existing 0x00000002 -> readback 0x00BB00DD.
- Channel ordering: W presented 3 cycles before AW -> WREADY accepts W immediately, AWREADY accepts AW on arrival. Commit occurs one edge after the AW handshake, with BVALID high at that point.
- Backpressure: hold BREADY=0 for 5 cycles after a write -> BVALID and BRESP stay stable, AWREADY and WREADY stay 0, and a second write is not accepted until the B handshake. The same check with RREADY=0: RDATA stays stable and ARREADY stays 0.
- Out of range: write 0x12345678 to 0x10, then read 0x10 -> BRESP=2'b10, RRESP=2'b10, RDATA=0, and registers 0..3 are unchanged.
- Reset mid-operation: assert ARESET after the AW handshake but before W -> all registers read 0 after release, no BVALID is produced, and the next full write completes with OKAY.
